// File: rtl/fifo_rd_stream_if.sv
// Bundle between the upstream sync FIFO read port, the downstream valid/ready stream and the transfer counter.
// master is the stream block's side, slave is the FIFO/consumer side.
interface fifo_rd_stream_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data_out;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [CNT_WIDTH-1:0]  pop_cnt;

  modport master (
    input  fifo_empty,
    input  fifo_data_out,
    input  m_ready,
    output fifo_rd_en,
    output m_data,
    output m_valid,
    output pop_cnt
  );

  modport slave (
    output fifo_empty,
    output fifo_data_out,
    output m_ready,
    input  fifo_rd_en,
    input  m_data,
    input  m_valid,
    input  pop_cnt
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Sync-FIFO read port to valid/ready stream via a 2-entry skid buffer; a pop shows on m_valid two cycles later.
// Under backpressure at most two words are ever outstanding, so nothing is dropped; full rate when m_ready stays high.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input logic             clk,
  input logic             rst_n,
  fifo_rd_stream_if.master bus
);

  logic [DATA_WIDTH-1:0] buf_q [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            occ;
  logic                  inflight;
  logic                  m_valid_q;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic [CNT_WIDTH-1:0]  pop_cnt_q;

  logic                  pop;
  logic                  rd_en;
  logic [2:0]            pending;
  logic [1:0]            occ_nxt;
  logic                  rd_ptr_nxt;
  logic                  wr_ptr_nxt;
  logic [DATA_WIDTH-1:0] m_data_nxt;

  always_comb begin
    pop     = m_valid_q & bus.m_ready;
    // Words that will still be held after this edge; cannot go negative since pop needs occ >= 1.
    pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    // rst_n gates the request so the FIFO is not popped while the buffer is held in reset.
    rd_en   = rst_n & ~bus.fifo_empty & (pending < 3'd2);

    rd_ptr_nxt = rd_ptr ^ pop;
    wr_ptr_nxt = wr_ptr ^ inflight;

    occ_nxt = occ;
    case ({inflight, pop})
      2'b10:   occ_nxt = occ + 2'd1;
      2'b01:   occ_nxt = occ - 2'd1;
      default: occ_nxt = occ;
    endcase

    // A word landing this edge in the slot the read pointer moves to bypasses the buffer.
    if (inflight && (wr_ptr == rd_ptr_nxt)) begin
      m_data_nxt = bus.fifo_data_out;
    end else begin
      m_data_nxt = buf_q[rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q[0]  <= '0;
      buf_q[1]  <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      occ       <= 2'd0;
      inflight  <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      pop_cnt_q <= '0;
    end else begin
      if (inflight) begin
        buf_q[wr_ptr] <= bus.fifo_data_out;
      end
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      occ       <= occ_nxt;
      inflight  <= rd_en;
      m_valid_q <= (occ_nxt != 2'd0);
      m_data_q  <= m_data_nxt;
      if (pop) begin
        pop_cnt_q <= pop_cnt_q + 1'b1;
      end
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_data     = m_data_q;
  assign bus.pop_cnt    = pop_cnt_q;

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of the FIFO read data and of the stream data.
REQ-002 Parameter CNT_WIDTH, default 8, width of the delivered-word counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 fifo_empty  input  1  empty flag of the upstream sync FIFO.
REQ-006 fifo_data_out  input  DATA_WIDTH  FIFO read data, valid in the cycle after the cycle in which fifo_rd_en was sampled high.
REQ-007 fifo_rd_en  output  1  FIFO pop request, one word per cycle high.
REQ-008 m_data  output  DATA_WIDTH  stream data to the consumer.
REQ-009 m_valid  output  1  m_data holds a valid word.
REQ-010 m_ready  input  1  consumer accepts the word; a transfer occurs when m_valid and m_ready are both high at a rising edge.
REQ-011 pop_cnt  output  CNT_WIDTH  count of completed stream transfers.

Function
REQ-012 The block SHALL hold a 2-entry output buffer with a 1-bit write pointer, a 1-bit read pointer and a 2-bit occupancy occ (0..2).
REQ-013 The block SHALL track one in-flight bit, set in the cycle after fifo_rd_en is high and cleared otherwise.
REQ-014 pop SHALL equal m_valid AND m_ready.
REQ-015 fifo_rd_en SHALL equal (NOT fifo_empty) AND (occ + inflight - pop < 2); this is combinational from m_ready and fifo_empty.
REQ-016 fifo_rd_en SHALL never be high while fifo_empty is high.
REQ-017 When inflight is high, the block SHALL write fifo_data_out into the buffer at the write pointer on the rising edge and advance the write pointer.
REQ-018 On pop, the block SHALL advance the read pointer.
REQ-019 occ SHALL change by +1 on capture only, by -1 on pop only, and remain unchanged on simultaneous capture and pop.
REQ-020 m_valid SHALL equal (occ != 0), and m_data SHALL be the buffer entry at the read pointer; both are register outputs.
REQ-021 While m_valid is high and m_ready is low, m_data SHALL be held stable.
REQ-022 Latency: a word popped with fifo_rd_en high in cycle N SHALL appear with m_valid high in cycle N+2.
REQ-023 Throughput: with fifo_empty low and m_ready held high, the block SHALL sustain one transfer per cycle.
REQ-024 occ + inflight SHALL never exceed 2, so no word is ever dropped or overwritten.
REQ-025 Words SHALL leave m_data in exactly the FIFO pop order, with no duplication.
REQ-026 pop_cnt SHALL increment by 1 on each pop and wrap from 2^CNT_WIDTH-1 to 0.

Reset
REQ-027 While rst_n is low, fifo_rd_en, m_valid, m_data, pop_cnt, occ, inflight and both pointers SHALL be 0 immediately, independent of clk.
REQ-028 A reset mid-operation SHALL discard buffered and in-flight words.
REQ-029 After rst_n deasserts, fifo_rd_en SHALL first assert in the first cycle in which fifo_empty is low.

Verification
REQ-030 Reset: assert rst_n=0 mid-stream with occ=2 -> m_valid=0, fifo_rd_en=0 and pop_cnt=0 without a clock edge; after release, no stale word appears.
REQ-031 Streaming: FIFO preloaded with 8 words 0x24,0x81,0x09,0x63,0x0D,0x8D,0x65,0x12 and m_ready=1 -> 8 consecutive fifo_rd_en cycles; m_valid high for 8 consecutive cycles starting 2 cycles after the first fifo_rd_en; data in order; pop_cnt=8; fifo_rd_en low once fifo_empty is high.
REQ-032 Backpressure: FIFO holds 5 words and m_ready=0 -> exactly 2 fifo_rd_en pulses; m_valid=1 with m_data=first word stable. Then m_ready=1 -> all 5 words delivered in order, pop_cnt=5.
REQ-033 Alternating m_ready 1/0 while the FIFO receives one write per cycle for 40 cycles -> scoreboard shows no loss, no duplicate and no reorder; occ+inflight never exceeds 2.
REQ-034 Empty FIFO: fifo_empty=1 for 20 cycles -> fifo_rd_en stays 0 and m_valid stays 0. A single word written -> m_valid rises 2 cycles after fifo_rd_en.
REQ-035 Counter wrap: 256 transfers with CNT_WIDTH=8 -> pop_cnt returns to 0x00, and the 257th transfer gives 0x01.
